// File: rtl/regfile_write_scheduler_if.sv
// Bundles the ALU/load writeback requests and the register-file write port.
// The master side is the pipeline; the slave side is regfile_write_scheduler.
interface regfile_write_scheduler_if #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 9
);
    logic                alu_valid;
    logic [ADDR_W-1:0]   alu_addr;
    logic [DATA_W-1:0]   alu_data;
    logic                mem_valid;
    logic                mem_ready;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_data;
    logic                writeEnable;
    logic [ADDR_W-1:0]   writeAddr;
    logic [DATA_W-1:0]   writeData;
    logic                init_done;
    logic [NUM_REGS-1:0] pending_mask;
    logic                err_addr;

    modport master (
        output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
        input  mem_ready, writeEnable, writeAddr, writeData, init_done,
               pending_mask, err_addr
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
        output mem_ready, writeEnable, writeAddr, writeData, init_done,
               pending_mask, err_addr
    );
endinterface

// File: rtl/regfile_write_scheduler.sv
// Arbitrates one regfile write port (ALU first, then queued loads), clears regs after reset.
// ALU latency 1 cycle, loads >= 2; loads backpressured via mem_ready when the queue is full.
module regfile_write_scheduler #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 4,
    parameter int NUM_REGS  = 9,
    parameter int MEM_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    regfile_write_scheduler_if.slave  bus
);
    localparam int                CNT_W    = $clog2(MEM_DEPTH + 1);
    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(MEM_DEPTH);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    typedef struct packed {
        logic              live;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    entry_t              queue_q [MEM_DEPTH];
    entry_t              queue_d [MEM_DEPTH];
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                init_done_q, init_done_d;
    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic                err_q, err_d;

    logic run, mem_ready, alu_ok, alu_err, mem_fire, mem_ok, mem_err, pop;

    // Credit comes from the registered count only, so a pop never frees a slot early.
    assign run       = (state_q == ST_RUN);
    assign mem_ready = run && (cnt_q < DEPTH_C);
    assign alu_ok    = run && bus.alu_valid && (bus.alu_addr <= LAST_REG);
    assign alu_err   = run && bus.alu_valid && (bus.alu_addr > LAST_REG);
    assign mem_fire  = bus.mem_valid && mem_ready;
    assign mem_ok    = mem_fire && (bus.mem_addr <= LAST_REG);
    assign mem_err   = mem_fire && (bus.mem_addr > LAST_REG);
    assign pop       = run && !alu_ok && (cnt_q != '0);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        queue_d     = queue_q;
        cnt_d       = cnt_q;
        we_d        = 1'b0;
        waddr_d     = '0;
        wdata_d     = '0;
        init_done_d = init_done_q;
        err_d       = 1'b0;
        pending_d   = '0;

        case (state_q)
            ST_INIT: begin
                we_d    = 1'b1;
                waddr_d = idx_q;
                idx_d   = idx_q + ADDR_W'(1);
                if (idx_q == LAST_REG) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            default: begin
                err_d = alu_err || mem_err;
                if (alu_ok) begin
                    we_d    = 1'b1;
                    waddr_d = bus.alu_addr;
                    wdata_d = bus.alu_data;
                end else if (pop && queue_q[0].live) begin
                    we_d    = 1'b1;
                    waddr_d = queue_q[0].addr;
                    wdata_d = queue_q[0].data;
                end
            end
        endcase

        if (pop) begin
            for (int i = 0; i < MEM_DEPTH - 1; i++) begin
                queue_d[i] = queue_q[i+1];
            end
            queue_d[MEM_DEPTH-1] = '0;
            cnt_d = cnt_q - CNT_W'(1);
        end

        if (mem_ok) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                if (CNT_W'(i) == cnt_d) begin
                    queue_d[i] = '{live: 1'b1, addr: bus.mem_addr, data: bus.mem_data};
                end
            end
            cnt_d = cnt_d + CNT_W'(1);
        end

        // The ALU write is younger than every queued load, including one accepted this cycle.
        if (alu_ok) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                if (queue_d[i].addr == bus.alu_addr) begin
                    queue_d[i].live = 1'b0;
                end
            end
        end

        for (int i = 0; i < MEM_DEPTH; i++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (queue_d[i].live && (queue_d[i].addr == ADDR_W'(r))) begin
                    pending_d[r] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_INIT;
            idx_q       <= '0;
            queue_q     <= '{default: '0};
            cnt_q       <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            init_done_q <= 1'b0;
            pending_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            queue_q     <= queue_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            init_done_q <= init_done_d;
            pending_q   <= pending_d;
            err_q       <= err_d;
        end
    end

    assign bus.mem_ready    = mem_ready;
    assign bus.writeEnable  = we_q;
    assign bus.writeAddr    = waddr_q;
    assign bus.writeData    = wdata_q;
    assign bus.init_done    = init_done_q;
    assign bus.pending_mask = pending_q;
    assign bus.err_addr     = err_q;
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler: init sweep, ALU/load arbitration,
// kill rule, illegal addresses and mid-operation reset.
module tb_regfile_write_scheduler;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    regfile_write_scheduler_if #(.DATA_W(32), .ADDR_W(4), .NUM_REGS(9)) bus ();

    regfile_write_scheduler #(
        .DATA_W(32), .ADDR_W(4), .NUM_REGS(9), .MEM_DEPTH(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alu(input logic v, input logic [3:0] a, input logic [31:0] d);
        bus.alu_valid = v;
        bus.alu_addr  = a;
        bus.alu_data  = d;
    endtask

    task automatic drive_mem(input logic v, input logic [3:0] a, input logic [31:0] d);
        bus.mem_valid = v;
        bus.mem_addr  = a;
        bus.mem_data  = d;
    endtask

    task automatic check_port(input string tag, input logic we, input logic [3:0] a,
                              input logic [31:0] d);
        check({tag, "_we"}, 32'(bus.writeEnable), 32'(we));
        if (we) begin
            check({tag, "_addr"}, 32'(bus.writeAddr), 32'(a));
            check({tag, "_data"}, bus.writeData, d);
        end
    endtask

    task automatic check_mask(input string tag, input logic [8:0] exp);
        check(tag, {23'b0, bus.pending_mask}, {23'b0, exp});
    endtask

    // Caller is in cycle 0 (first cycle with reset low); returns in cycle 9.
    task automatic init_walk(input bit with_alu);
        if (with_alu) drive_alu(1'b1, 4'd3, 32'hBAD);
        for (int c = 1; c <= 9; c++) begin
            tick;
            check_port("init_wr", 1'b1, 4'(c - 1), 32'h0);
            check("init_done", 32'(bus.init_done), (c == 9) ? 32'd1 : 32'd0);
            check("init_mem_ready", 32'(bus.mem_ready), (c == 9) ? 32'd1 : 32'd0);
            check("init_err", 32'(bus.err_addr), 32'd0);
            if (c == 8) drive_alu(1'b0, 4'd0, 32'h0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        drive_alu(1'b0, 4'd0, 32'h0);
        drive_mem(1'b0, 4'd0, 32'h0);
        repeat (3) tick;
        check("rst_we", 32'(bus.writeEnable), 32'd0);
        check("rst_init_done", 32'(bus.init_done), 32'd0);
        check_mask("rst_mask", 9'h0);
        check("rst_err", 32'(bus.err_addr), 32'd0);
        check("rst_mem_ready", 32'(bus.mem_ready), 32'd0);
        reset = 1'b0;
        check("c0_mem_ready", 32'(bus.mem_ready), 32'd0);
        init_walk(1'b0);

        // Single ALU write: port shows it in exactly one cycle.
        drive_alu(1'b1, 4'd3, 32'hDEADBEEF);
        tick;
        drive_alu(1'b0, 4'd0, 32'h0);
        check_port("alu_r3", 1'b1, 4'd3, 32'hDEADBEEF);
        tick;
        check_port("alu_r3_after", 1'b0, 4'd0, 32'h0);

        // Two loads queued under a 3-cycle ALU burst.
        drive_mem(1'b1, 4'd1, 32'h11);
        drive_alu(1'b1, 4'd5, 32'h55);
        check("ld1_ready", 32'(bus.mem_ready), 32'd1);
        tick;
        check_mask("ld1_mask", 9'h002);
        check("ld2_ready", 32'(bus.mem_ready), 32'd1);
        check_port("burst1", 1'b1, 4'd5, 32'h55);
        drive_mem(1'b1, 4'd2, 32'h22);
        tick;
        drive_mem(1'b0, 4'd0, 32'h0);
        check("full_ready", 32'(bus.mem_ready), 32'd0);
        check_mask("full_mask", 9'h006);
        check_port("burst2", 1'b1, 4'd5, 32'h55);
        tick;
        drive_alu(1'b0, 4'd0, 32'h0);
        check_port("burst3", 1'b1, 4'd5, 32'h55);
        check_mask("burst3_mask", 9'h006);
        check("burst3_ready", 32'(bus.mem_ready), 32'd0);
        tick;
        check_port("pop_r1", 1'b1, 4'd1, 32'h11);
        check_mask("pop_r1_mask", 9'h004);
        check("pop_r1_ready", 32'(bus.mem_ready), 32'd1);
        tick;
        check_port("pop_r2", 1'b1, 4'd2, 32'h22);
        check_mask("pop_r2_mask", 9'h000);
        tick;
        check_port("drained", 1'b0, 4'd0, 32'h0);

        // Queued load to r4 killed by a younger ALU write.
        drive_mem(1'b1, 4'd4, 32'h44);
        tick;
        drive_mem(1'b0, 4'd0, 32'h0);
        check_mask("r4_pend", 9'h010);
        check_port("r4_wait", 1'b0, 4'd0, 32'h0);
        drive_alu(1'b1, 4'd4, 32'h99);
        tick;
        drive_alu(1'b0, 4'd0, 32'h0);
        check_port("r4_alu", 1'b1, 4'd4, 32'h99);
        check_mask("r4_killed_mask", 9'h000);
        tick;
        check_port("r4_killed_pop", 1'b0, 4'd0, 32'h0);
        tick;
        check_port("r4_idle", 1'b0, 4'd0, 32'h0);

        // Same-cycle load and ALU write to r6.
        drive_mem(1'b1, 4'd6, 32'h66);
        drive_alu(1'b1, 4'd6, 32'h77);
        tick;
        drive_mem(1'b0, 4'd0, 32'h0);
        drive_alu(1'b0, 4'd0, 32'h0);
        check_port("r6_alu", 1'b1, 4'd6, 32'h77);
        check_mask("r6_mask0", 9'h000);
        tick;
        check_port("r6_killed_pop", 1'b0, 4'd0, 32'h0);
        check_mask("r6_mask1", 9'h000);

        // Illegal addresses.
        drive_alu(1'b1, 4'd9, 32'h9);
        tick;
        drive_alu(1'b0, 4'd0, 32'h0);
        check_port("bad_alu", 1'b0, 4'd0, 32'h0);
        check("bad_alu_err", 32'(bus.err_addr), 32'd1);
        drive_mem(1'b1, 4'd12, 32'hC);
        check("bad_mem_ready", 32'(bus.mem_ready), 32'd1);
        tick;
        drive_mem(1'b0, 4'd0, 32'h0);
        check_port("bad_mem", 1'b0, 4'd0, 32'h0);
        check("bad_mem_err", 32'(bus.err_addr), 32'd1);
        check_mask("bad_mem_mask", 9'h000);
        check("bad_mem_ready_after", 32'(bus.mem_ready), 32'd1);
        tick;
        check("err_clear", 32'(bus.err_addr), 32'd0);
        check_port("bad_mem_pop", 1'b0, 4'd0, 32'h0);
        drive_alu(1'b1, 4'd10, 32'hA);
        drive_mem(1'b1, 4'd15, 32'hF);
        tick;
        drive_alu(1'b0, 4'd0, 32'h0);
        drive_mem(1'b0, 4'd0, 32'h0);
        check("both_err", 32'(bus.err_addr), 32'd1);
        check_port("both_bad", 1'b0, 4'd0, 32'h0);
        tick;
        check("both_err_single", 32'(bus.err_addr), 32'd0);
        check_port("both_bad_pop", 1'b0, 4'd0, 32'h0);

        // Fill the queue behind an ALU stream, then reset.
        drive_alu(1'b1, 4'd0, 32'h1);
        drive_mem(1'b1, 4'd7, 32'h70);
        tick;
        drive_mem(1'b1, 4'd8, 32'h80);
        check_port("fill_alu", 1'b1, 4'd0, 32'h1);
        check("fill_ready", 32'(bus.mem_ready), 32'd1);
        tick;
        drive_mem(1'b0, 4'd0, 32'h0);
        drive_alu(1'b0, 4'd0, 32'h0);
        check_mask("fill_mask", 9'h180);
        check("fill_full", 32'(bus.mem_ready), 32'd0);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check_port("rst2_port", 1'b0, 4'd0, 32'h0);
        check_mask("rst2_mask", 9'h000);
        check("rst2_init_done", 32'(bus.init_done), 32'd0);
        check("rst2_mem_ready", 32'(bus.mem_ready), 32'd0);
        init_walk(1'b1);
        tick;
        check_port("post_init_idle", 1'b0, 4'd0, 32'h0);
        check_mask("post_init_mask", 9'h000);
        tick;
        check_port("post_init_idle2", 1'b0, 4'd0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/regfile_write_scheduler.md
# regfile_write_scheduler

Shares the register file's single write port between the ALU writeback path and the memory (load) writeback path, and clears registers 0..8 after reset. Sits between the pipeline writeback stages and the register file write port (writeEnable/writeAddr/writeData). It also exports a pending-write mask so hazard logic can stall reads of registers whose load data is still queued.

## Interface
- DATA_W, 32, data width
- ADDR_W, 4, register address width
- NUM_REGS, 9, writable registers 0..NUM_REGS-1; address 9 (PC+8 alias) and above are not writable
- MEM_DEPTH, 2, load-write queue depth

- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- alu_valid  in  1  ALU writeback request this cycle (no ready; always accepted in RUN)
- alu_addr  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- mem_valid  in  1  load writeback request
- mem_ready  out  1  load request accepted when mem_valid && mem_ready
- mem_addr  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- writeEnable  out  1  to register file
- writeAddr  out  ADDR_W  to register file
- writeData  out  DATA_W  to register file
- init_done  out  1  high once clearing is complete
- pending_mask  out  NUM_REGS  bit i = live queued load write to register i
- err_addr  out  1  one-cycle pulse: a request targeted an address >= NUM_REGS

## Operation
- States: INIT, RUN. Reset forces INIT, idx=0, queue empty, all outputs 0.
- INIT: each edge registers writeEnable=1, writeAddr=idx, writeData=0, then idx++. The edge that presents idx=NUM_REGS-1 moves to RUN and sets init_done=1. During INIT: mem_ready=0; alu_valid ignored (no write, no error).
- RUN arbitration per cycle, ALU has strict priority:
  - alu_valid with addr < NUM_REGS: next-edge port write (1, alu_addr, alu_data). Queue does not drain.
  - else, queue head present: pop it; if head live, port write (1, addr, data); if killed, writeEnable=0 (slot consumed).
  - else writeEnable=0.
- Queue: FIFO of {addr, data, live}. mem_ready = RUN && count < MEM_DEPTH, computed from current count only (no same-cycle pop credit). An accepted entry is poppable no earlier than the next cycle; there is no bypass.
- Kill rule: the ALU write is younger than any queued load. An accepted ALU write to A clears live on every queued entry with addr A at that edge. This includes an entry enqueued in the same cycle with mem_addr == A.
- Illegal address (>= NUM_REGS): the ALU request is dropped. A load request is handshaken (mem_ready honored) and discarded, not enqueued. err_addr pulses on the next edge; simultaneous ALU and mem errors give a single pulse.
- pending_mask: OR of decoded addr over live queued entries, registered with the queue state.
- Reset mid-operation: queue flushed, pending_mask=0, init_done=0, INIT restarts at idx 0.

## Timing
- Cycle 0 = first cycle with reset low. INIT writes to regs 0..8 appear on the port in cycles 1..9. init_done=1 from cycle 9. First RUN request is sampled in cycle 9 and appears on the port in cycle 10.
- All outputs except mem_ready are registered. Request-to-port latency is 1 cycle for the ALU. For a load it is ≥2 cycles: enqueue edge, then pop edge.
- The register file commits at the edge ending the cycle the port shows the write. A read of a load-target register is safe once its pending_mask bit is 0 and a further cycle has elapsed.
- mem_ready is combinational from state (not from mem_valid or alu_valid).

## Test plan
- Reset held 3 cycles, then released -> port shows addr 0..8, data 0, cycles 1..9. init_done=1 from cycle 9. mem_ready=0 before cycle 9.
- RUN: alu_valid, addr 3, data 0xDEADBEEF in cycle k -> writeEnable=1, addr 3, data 0xDEADBEEF in cycle k+1 only.
- Loads to r1 (0x11) and r2 (0x22) in consecutive cycles, alu_valid held high with r5 for 3 cycles -> mem_ready=0 after the two loads. pending_mask=0x006. r1 and r2 appear on the port after the ALU burst, in order. The mask clears bit by bit.
- Load to r4 (0x44) queued, then ALU write r4=0x99 before drain -> port shows r4=0x99. The queued pop produces writeEnable=0. pending_mask bit 4 clears at the ALU accept edge. Final value of r4 is 0x99.
- Same-cycle mem r6=0x66 and ALU r6=0x77 -> only r6=0x77 is written. pending_mask bit 6 is never set.
- ALU addr 9, then load addr 12 (handshaken) -> no port write for either. err_addr pulses once per request. Queue count is unchanged. Reset asserted with 2 queued entries -> queue empty, INIT restarts at addr 0.
